pc_unit: RTL and testbench
==========================

Name: pc_unit

Overview:
- Parametrised program-counter block; successor to the fixed 32-bit enable-gated PC register.
- Generates the fetch address each cycle: sequential increment, conditional branch, jump, and call/return through an internal return-address stack (RAS).
- Sits at the front of the fetch stage. Its `pc` output drives instruction memory address.

Parameters:
- WIDTH, 32, PC width in bits
- RESET_PC, 32'h0000_3000, PC value loaded on reset (truncated to WIDTH)
- STEP, 4, sequential increment in bytes
- DEPTH, 4, RAS entries (power of two, >=2)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-low reset
- ena  input  1  global enable; 0 freezes all state
- stall  input  1  pipeline stall; 1 holds PC and RAS
- br_taken  input  1  conditional branch taken this cycle
- br_target  input  WIDTH  branch destination
- jmp  input  1  unconditional jump
- call  input  1  jump plus push return address (uses jmp_target)
- ret  input  1  pop RAS and jump to popped address
- jmp_target  input  WIDTH  jump/call destination
- pc  output  WIDTH  current fetch address, registered
- ras_full  output  1  RAS holds DEPTH entries
- ras_empty  output  1  RAS holds 0 entries
- ras_err  output  1  sticky: return issued with empty RAS

Behaviour:
- rst low (async, any time, including mid-operation):
  - pc=RESET_PC, RAS count=0, ras_empty=1, ras_full=0, ras_err=0.
  - Deassertion takes effect at the next rising edge.
- All updates happen on the rising clk edge. pc reflects a request one cycle after that request is sampled; there is no combinational path from inputs to pc.
- Priority per edge: ena=0 (hold everything) > stall=1 (hold everything) > ret > call > jmp > br_taken > sequential.
- Sequential: pc <= pc+STEP, modulo 2^WIDTH. The all-ones region wraps to 0 with no flag.
- br_taken: pc <= br_target.
- jmp: pc <= jmp_target.
- call: push pc+STEP (mod 2^WIDTH), then pc <= jmp_target.
  - If the RAS is full, the push overwrites the oldest entry (circular), count stays DEPTH, no error.
- ret with RAS non-empty: pc <= top entry, count decrements.
- ret with RAS empty: pc <= pc+STEP, ras_err <= 1. ras_err stays set until rst.
- Simultaneous call and ret: ret wins, no push. Lower-priority requests are ignored that cycle.
- Targets are used as given; no alignment masking in the base build.
- RAS storage:
  - Circular buffer with a top pointer mod DEPTH and a count 0..DEPTH.
  - ras_full and ras_empty are decoded from the registered count.
  - Entry contents are don't-care after reset.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- When defined:
  - Adds parameter TRAP_PC (default 32'h0000_0004) and output `misalign` (1 bit, sticky, cleared only by rst).
  - Misaligned means a selected next-PC from br_target, jmp_target or a popped RAS entry with nonzero low log2(STEP) bits.
  - On a misaligned next-PC: pc <= TRAP_PC and misalign <= 1. The RAS update for that cycle still occurs.
- When undefined: no `misalign` port, no TRAP_PC, targets pass unmodified.

Test Plan:
- Reset and increment: hold rst=0 for 2 cycles, release, ena=1, no requests → pc 0x3000, then 0x3004, 0x3008 on successive edges; ras_empty=1.
- Hold and async reset:
  - ena=0 for 3 cycles at pc=0x3008 → pc stays 0x3008.
  - stall=1 with jmp=1 → pc unchanged, jmp lost.
  - rst pulsed low between edges → pc=0x3000 immediately, without waiting for an edge.
- Control flow and priority:
  - br_taken=1 with br_target=0x4000 → pc=0x4000.
  - Next cycle jmp=1 and br_taken=1, jmp_target=0x5000, br_target=0x6000 → pc=0x5000 (jmp beats branch).
- Nested calls and returns:
  - At pc=0x3000, call to 0x100. At 0x100, call to 0x200.
  - ret → pc=0x104. ret → pc=0x3004. ras_empty=1, ras_err=0.
- RAS overflow, underflow and wrap:
  - 5 consecutive calls (DEPTH=4) → ras_full=1. Then 4 rets return the 4 newest return addresses, newest first. The oldest is lost.
  - A 5th ret → pc+4, ras_err=1, and ras_err stays 1 until rst.
  - Sequential wrap: jmp to 0xFFFF_FFFC then idle → pc=0x0000_0000.
- With PC_MISALIGN_TRAP_EN:
  - jmp to 0x5002 → pc=0x0000_0004, misalign=1.
  - Aligned jmp afterwards → normal pc update, misalign stays 1.
  - Without the macro, jmp to 0x5002 → pc=0x5002.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter with branch/jump/call/return and a circular return-address stack.
// Optional PC_MISALIGN_TRAP_EN: misaligned targets redirect to TRAP_PC and set sticky misalign.
module pc_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned STEP     = 4,
  parameter int unsigned DEPTH    = 4
`ifdef PC_MISALIGN_TRAP_EN
  ,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0004
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [WIDTH-1:0] br_target,
  input  logic             jmp,
  input  logic             call,
  input  logic             ret,
  input  logic [WIDTH-1:0] jmp_target,
  output logic [WIDTH-1:0] pc,
  output logic             ras_full,
  output logic             ras_empty,
  output logic             ras_err
`ifdef PC_MISALIGN_TRAP_EN
  ,
  output logic             misalign
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] RST_W   = RESET_PC[WIDTH-1:0];
  localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] ras_mem [DEPTH];
  logic [PTR_W-1:0] top_reg;
  logic [PTR_W:0]   count_reg;

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] pc_next;
  logic             push;
  logic             pop;
  logic             err_set;
  logic             from_target;
  logic             advance;

  assign advance = ena && !stall;
  assign seq_pc  = pc + STEP_W;

  always_comb begin
    pc_next     = seq_pc;
    push        = 1'b0;
    pop         = 1'b0;
    err_set     = 1'b0;
    from_target = 1'b0;
    if (ret) begin
      if (count_reg != '0) begin
        pc_next     = ras_mem[top_reg];
        pop         = 1'b1;
        from_target = 1'b1;
      end else begin
        err_set = 1'b1;
      end
    end else if (call) begin
      pc_next     = jmp_target;
      push        = 1'b1;
      from_target = 1'b1;
    end else if (jmp) begin
      pc_next     = jmp_target;
      from_target = 1'b1;
    end else if (br_taken) begin
      pc_next     = br_target;
      from_target = 1'b1;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [WIDTH-1:0] ALIGN_MASK = STEP_W - WIDTH'(1);
  logic misaligned;
  assign misaligned = from_target && ((pc_next & ALIGN_MASK) != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      misalign <= 1'b0;
    end else if (advance && misaligned) begin
      misalign <= 1'b1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc        <= RST_W;
      top_reg   <= '0;
      count_reg <= '0;
      ras_err   <= 1'b0;
    end else if (advance) begin
`ifdef PC_MISALIGN_TRAP_EN
      pc <= misaligned ? TRAP_PC[WIDTH-1:0] : pc_next;
`else
      pc <= pc_next;
`endif
      if (push) begin
        // A full stack simply overwrites its oldest slot; the count saturates.
        top_reg <= top_reg + 1'b1;
        if (count_reg != DEPTH_C) count_reg <= count_reg + 1'b1;
      end else if (pop) begin
        top_reg   <= top_reg - 1'b1;
        count_reg <= count_reg - 1'b1;
      end
      if (err_set) ras_err <= 1'b1;
    end
  end

  // Storage is not reset; contents are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (advance && push) begin
      ras_mem[top_reg + 1'b1] <= seq_pc;
    end
  end

  assign ras_full  = (count_reg == DEPTH_C);
  assign ras_empty = (count_reg == '0);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: reset, hold, control flow, RAS nesting/overflow/underflow, wrap.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ena = 1'b0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp = 1'b0;
  logic        call = 1'b0;
  logic        ret = 1'b0;
  logic [31:0] jmp_target = '0;
  logic [31:0] pc;
  logic        ras_full;
  logic        ras_empty;
  logic        ras_err;
`ifdef PC_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_cmp = 0;
  int n_err = 0;

  pc_unit dut (
    .clk(clk), .rst(rst), .ena(ena), .stall(stall),
    .br_taken(br_taken), .br_target(br_target),
    .jmp(jmp), .call(call), .ret(ret), .jmp_target(jmp_target),
    .pc(pc), .ras_full(ras_full), .ras_empty(ras_empty), .ras_err(ras_err)
`ifdef PC_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    br_taken = 0; jmp = 0; call = 0; ret = 0; stall = 0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic do_call(input logic [31:0] t);
    idle(); call = 1; jmp_target = t; tick(); idle();
  endtask

  task automatic do_ret();
    idle(); ret = 1; tick(); idle();
  endtask

  initial begin
    #1 rst = 1'b0;
    #2;
    check_eq("rst_pc", pc, 32'h3000);
    check_eq("rst_empty", {31'b0, ras_empty}, 32'd1);
    check_eq("rst_full", {31'b0, ras_full}, 32'd0);
    check_eq("rst_err", {31'b0, ras_err}, 32'd0);
    tick(); tick();
    rst = 1'b1; ena = 1'b1;
    check_eq("rel_pc", pc, 32'h3000);
    tick(); check_eq("inc1", pc, 32'h3004);
    tick(); check_eq("inc2", pc, 32'h3008);
    check_eq("inc_empty", {31'b0, ras_empty}, 32'd1);

    ena = 1'b0;
    tick(); tick(); tick();
    check_eq("ena_hold", pc, 32'h3008);
    ena = 1'b1; stall = 1'b1; jmp = 1'b1; jmp_target = 32'h9000;
    tick();
    check_eq("stall_hold", pc, 32'h3008);
    idle(); tick();
    check_eq("after_stall", pc, 32'h300C);

    rst = 1'b0; #2;
    check_eq("async_rst", pc, 32'h3000);
    rst = 1'b1;

    br_taken = 1; br_target = 32'h4000; tick();
    check_eq("branch", pc, 32'h4000);
    jmp = 1; jmp_target = 32'h5000; br_target = 32'h6000; tick(); idle();
    check_eq("jmp_over_br", pc, 32'h5000);

    pulse_reset();
    check_eq("rst2_pc", pc, 32'h3000);
    do_call(32'h100); check_eq("call1", pc, 32'h100);
    do_call(32'h200); check_eq("call2", pc, 32'h200);
    do_ret(); check_eq("ret1", pc, 32'h104);
    do_ret(); check_eq("ret2", pc, 32'h3004);
    check_eq("nest_empty", {31'b0, ras_empty}, 32'd1);
    check_eq("nest_err", {31'b0, ras_err}, 32'd0);

    for (int i = 1; i <= 5; i++) do_call(32'h1000 * i);
    check_eq("ovf_pc", pc, 32'h5000);
    check_eq("ovf_full", {31'b0, ras_full}, 32'd1);
    do_ret(); check_eq("ovf_ret1", pc, 32'h4004);
    check_eq("ovf_notfull", {31'b0, ras_full}, 32'd0);
    do_ret(); check_eq("ovf_ret2", pc, 32'h3004);
    do_ret(); check_eq("ovf_ret3", pc, 32'h2004);
    do_ret(); check_eq("ovf_ret4", pc, 32'h1004);
    check_eq("ovf_empty", {31'b0, ras_empty}, 32'd1);
    check_eq("pre_udf_err", {31'b0, ras_err}, 32'd0);
    do_ret(); check_eq("udf_pc", pc, 32'h1008);
    check_eq("udf_err", {31'b0, ras_err}, 32'd1);
    tick(); check_eq("udf_seq", pc, 32'h100C);
    check_eq("err_sticky", {31'b0, ras_err}, 32'd1);
    call = 1; ret = 1; jmp_target = 32'h7000; tick(); idle();
    check_eq("callret_pc", pc, 32'h1010);
    check_eq("callret_empty", {31'b0, ras_empty}, 32'd1);

    jmp = 1; jmp_target = 32'hFFFF_FFFC; tick(); idle();
    check_eq("wrap_jmp", pc, 32'hFFFF_FFFC);
    tick(); check_eq("wrap_zero", pc, 32'h0000_0000);
    check_eq("err_still", {31'b0, ras_err}, 32'd1);
    pulse_reset();
    check_eq("err_cleared", {31'b0, ras_err}, 32'd0);

`ifdef PC_MISALIGN_TRAP_EN
    check_eq("mis_rst", {31'b0, misalign}, 32'd0);
    jmp = 1; jmp_target = 32'h5002; tick(); idle();
    check_eq("trap_pc", pc, 32'h0000_0004);
    check_eq("trap_flag", {31'b0, misalign}, 32'd1);
    jmp = 1; jmp_target = 32'h6000; tick(); idle();
    check_eq("aligned_after", pc, 32'h6000);
    check_eq("flag_sticky", {31'b0, misalign}, 32'd1);
`else
    jmp = 1; jmp_target = 32'h5002; tick(); idle();
    check_eq("unaligned_pass", pc, 32'h5002);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
